// File: rtl/dac_sample_feeder.sv
// dac_sample_feeder: 12-bit sample FIFO plus sample-rate timer that paces dacdav/davdac handshakes.
// Build option DAC_REPEAT_LAST_EN: a tick that finds the FIFO empty re-sends the last sample.
module dac_sample_feeder #(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned DIV_W      = 16
) (
    input  logic                  dacclk,
    input  logic                  dacrst,
    input  logic                  wr_en,
    input  logic [11:0]           wr_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level,
    input  logic                  enable,
    input  logic [DIV_W-1:0]      rate_div,
    output logic                  dacdav,
    output logic [11:0]           dacdata,
    input  logic                  davdac,
    output logic                  busy,
    input  logic                  status_clr,
    output logic                  underrun,
    output logic                  late_tick,
    output logic                  wr_drop
);

    localparam int unsigned         Depth    = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DepthCnt = (DEPTH_LOG2 + 1)'(Depth);

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StRel
    } state_e;

    state_e                state_q;
    logic                  dacdav_q;
    logic [11:0]           dacdata_q;
    logic [DIV_W-1:0]      count_q;
    logic [DIV_W-1:0]      count_d;
    logic                  tick;
    logic [11:0]           mem [Depth];
    logic [DEPTH_LOG2-1:0] wr_ptr_q;
    logic [DEPTH_LOG2-1:0] rd_ptr_q;
    logic [DEPTH_LOG2:0]   level_q;
    logic                  push;
    logic                  pop;
    logic                  tick_idle;
    logic                  start_rep;
    logic                  underrun_q;
    logic                  late_tick_q;
    logic                  wr_drop_q;

    // Sample timer; >= keeps the count bounded if rate_div is lowered mid-period.
    always_comb begin
        tick    = 1'b0;
        count_d = '0;
        if (enable) begin
            if (count_q >= rate_div) begin
                tick = 1'b1;
            end else begin
                count_d = count_q + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge dacclk) begin
        if (dacrst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign full      = (level_q == DepthCnt);
    assign empty     = (level_q == '0);
    assign level     = level_q;
    assign busy      = (state_q != StIdle);
    assign push      = wr_en & ~full;
    assign tick_idle = tick & (state_q == StIdle);
    assign pop       = tick_idle & ~empty;

`ifdef DAC_REPEAT_LAST_EN
    assign start_rep = tick_idle & empty;
`else
    assign start_rep = 1'b0;
`endif

    always_ff @(posedge dacclk) begin
        if (dacrst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + (DEPTH_LOG2 + 1)'(1);
                2'b01:   level_q <= level_q - (DEPTH_LOG2 + 1)'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Storage is not reset; only pointers and level define contents.
    always_ff @(posedge dacclk) begin
        if (push) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge dacclk) begin
        if (dacrst) begin
            state_q   <= StIdle;
            dacdav_q  <= 1'b0;
            dacdata_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (pop) begin
                        dacdata_q <= mem[rd_ptr_q];
                        dacdav_q  <= 1'b1;
                        state_q   <= StSend;
                    end else if (start_rep) begin
                        dacdav_q <= 1'b1;
                        state_q  <= StSend;
                    end
                end
                StSend: begin
                    if (davdac) begin
                        dacdav_q <= 1'b0;
                        state_q  <= StRel;
                    end
                end
                // One low cycle lets the driver drop davdac before the next request.
                StRel: begin
                    state_q <= StIdle;
                end
                default: begin
                    dacdav_q <= 1'b0;
                    state_q  <= StIdle;
                end
            endcase
        end
    end

    assign dacdav  = dacdav_q;
    assign dacdata = dacdata_q;

    // Sticky flags: a new set event beats a coincident clear.
    always_ff @(posedge dacclk) begin
        if (dacrst) begin
            underrun_q  <= 1'b0;
            late_tick_q <= 1'b0;
            wr_drop_q   <= 1'b0;
        end else begin
            underrun_q  <= (tick_idle & empty) | (underrun_q & ~status_clr);
            late_tick_q <= (tick & busy) | (late_tick_q & ~status_clr);
            wr_drop_q   <= (wr_en & full) | (wr_drop_q & ~status_clr);
        end
    end

    assign underrun  = underrun_q;
    assign late_tick = late_tick_q;
    assign wr_drop   = wr_drop_q;

endmodule

// File: tb/tb_dac_sample_feeder.sv
// Scoreboard bench for dac_sample_feeder: expected samples queued at push, checked at each dacdav rise.
module tb_dac_sample_feeder;

`ifdef DAC_REPEAT_LAST_EN
    localparam bit RepeatEn = 1'b1;
`else
    localparam bit RepeatEn = 1'b0;
`endif

    logic        dacclk = 1'b0;
    logic        dacrst;
    logic        wr_en;
    logic [11:0] wr_data;
    logic        full;
    logic        empty;
    logic [4:0]  level;
    logic        enable;
    logic [15:0] rate_div;
    logic        dacdav;
    logic [11:0] dacdata;
    logic        davdac = 1'b0;
    logic        busy;
    logic        status_clr;
    logic        underrun;
    logic        late_tick;
    logic        wr_drop;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          drv_lat = 2;
    int          drv_cnt = 0;
    logic [11:0] exp_q[$];
    int          rises[$];
    int          t0;

    dac_sample_feeder #(
        .DEPTH_LOG2(4),
        .DIV_W     (16)
    ) dut (
        .dacclk    (dacclk),
        .dacrst    (dacrst),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .full      (full),
        .empty     (empty),
        .level     (level),
        .enable    (enable),
        .rate_div  (rate_div),
        .dacdav    (dacdav),
        .dacdata   (dacdata),
        .davdac    (davdac),
        .busy      (busy),
        .status_clr(status_clr),
        .underrun  (underrun),
        .late_tick (late_tick),
        .wr_drop   (wr_drop)
    );

    always #5 dacclk = ~dacclk;

    always @(posedge dacclk) cyc <= cyc + 1;

    // Driver model: raise davdac drv_lat+1 cycles into a request, drop it once dacdav falls.
    always @(posedge dacclk) begin
        if (dacrst || !dacdav) begin
            davdac  <= 1'b0;
            drv_cnt <= 0;
        end else if (!davdac) begin
            if (drv_cnt >= drv_lat) begin
                davdac  <= 1'b1;
                drv_cnt <= 0;
            end else begin
                drv_cnt <= drv_cnt + 1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Monitor: compare each new transfer against the scoreboard head.
    initial begin
        logic        dav_prev = 1'b0;
        logic [11:0] held = '0;
        int          fall_cyc = -100;
        forever begin
            @(negedge dacclk);
            if (dacdav === 1'b1 && !dav_prev) begin
                rises.push_back(cyc);
                check("dav_low_gap_ge2", 32'(cyc - fall_cyc >= 2), 32'd1);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_transfer: got dacdata %0h want no transfer", dacdata);
                end else begin
                    check("dacdata", 32'(dacdata), 32'(exp_q.pop_front()));
                end
                held = dacdata;
            end else if (dacdav === 1'b1 && dav_prev) begin
                check("dacdata_stable", 32'(dacdata), 32'(held));
            end
            if (dacdav !== 1'b1 && dav_prev) fall_cyc = cyc;
            dav_prev = (dacdav === 1'b1);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge dacclk);
        #1;
    endtask

    task automatic push(input logic [11:0] d, input bit will_send);
        wr_en   = 1'b1;
        wr_data = d;
        if (will_send) exp_q.push_back(d);
        step();
        wr_en = 1'b0;
    endtask

    task automatic pulse_clr();
        status_clr = 1'b1;
        step();
        status_clr = 1'b0;
    endtask

    task automatic wait_rises(input int n, input int budget, input string name);
        int k = 0;
        while (rises.size() < n && k < budget) begin
            @(negedge dacclk);
            #1;
            k++;
        end
        check(name, 32'(rises.size() >= n), 32'd1);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int k = 0;
        while (busy !== 1'b0 && k < budget) begin
            @(negedge dacclk);
            #1;
            k++;
        end
        check(name, 32'(busy), 32'd0);
    endtask

    function automatic int rise_at(input int i);
        return (rises.size() > i) ? rises[i] : -1;
    endfunction

    initial begin
        dacrst = 1'b1; wr_en = 1'b0; wr_data = '0; enable = 1'b0;
        rate_div = '0; status_clr = 1'b0;
        repeat (3) step();
        @(negedge dacclk);
        check("rst_level", 32'(level), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_dacdav", 32'(dacdav), 32'd0);
        check("rst_dacdata", 32'(dacdata), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_flags", 32'({underrun, late_tick, wr_drop}), 32'd0);
        step();
        dacrst = 1'b0;

        // T1: two samples at rate_div=9
        push(12'h123, 1'b1);
        push(12'hABC, 1'b1);
        check("t1_level", 32'(level), 32'd2);
        rate_div = 16'd9;
        enable   = 1'b1;
        t0       = cyc;
        wait_rises(2, 60, "t1_two_transfers");
        enable = 1'b0;
        check("t1_first_latency", 32'(rise_at(0) - t0), 32'd10);
        check("t1_period", 32'(rise_at(1) - rise_at(0)), 32'd10);
        wait_idle(40, "t1_idle");
        check("t1_underrun", 32'(underrun), 32'd0);
        check("t1_empty", 32'(empty), 32'd1);

        // T2: slow driver, ticks land while busy
        rises.delete();
        drv_lat = 33;
        push(12'h111, 1'b1);
        push(12'h222, 1'b1);
        push(12'h333, 1'b1);
        rate_div = 16'd3;
        enable   = 1'b1;
        wait_rises(3, 400, "t2_three_transfers");
        enable = 1'b0;
        wait_idle(100, "t2_idle");
        check("t2_late_tick", 32'(late_tick), 32'd1);
        check("t2_underrun", 32'(underrun), 32'd0);
        check("t2_level", 32'(level), 32'd0);
        pulse_clr();
        @(negedge dacclk);
        check("t2_clr_late", 32'(late_tick), 32'd0);

        // T3: overfill with timer off; clear coincides with the drop
        for (int i = 0; i < 16; i++) push(12'h400 + 12'(i), 1'b1);
        @(negedge dacclk);
        check("t3_full", 32'(full), 32'd1);
        check("t3_level16", 32'(level), 32'd16);
        check("t3_no_drop_yet", 32'(wr_drop), 32'd0);
        status_clr = 1'b1;
        push(12'h7EE, 1'b0);
        status_clr = 1'b0;
        @(negedge dacclk);
        check("t3_drop_wins_clr", 32'(wr_drop), 32'd1);
        check("t3_level_kept", 32'(level), 32'd16);

        // T4: drain, then one tick on an empty FIFO
        rises.delete();
        drv_lat  = 1;
        rate_div = 16'd0;
        enable   = 1'b1;
        if (RepeatEn) exp_q.push_back(12'h40F);
        wait_rises(16, 300, "t4_drain");
        wait_idle(20, "t4_idle_after_drain");
        step();
        enable = 1'b0;
        @(negedge dacclk);
        check("t4_underrun", 32'(underrun), 32'd1);
        check("t4_dacdav_after_underrun", 32'(dacdav), 32'(RepeatEn));
        wait_idle(40, "t4_idle");
        repeat (3) step();
        check("t4_dacdata_kept", 32'(dacdata), 32'h40F);
        check("t4_empty", 32'(empty), 32'd1);

        // T5: reset in the middle of a handshake
        rises.delete();
        drv_lat = 20;
        push(12'h5A5, 1'b1);
        push(12'h0F0, 1'b0);
        enable = 1'b1;
        wait_rises(1, 20, "t5_transfer");
        step();
        @(negedge dacclk);
        check("t5_in_send", 32'({dacdav, busy}), 32'd3);
        dacrst = 1'b1;
        enable = 1'b0;
        @(negedge dacclk);
        check("t5_rst_dacdav", 32'(dacdav), 32'd0);
        check("t5_rst_level", 32'(level), 32'd0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_flags", 32'({underrun, late_tick, wr_drop}), 32'd0);
        check("t5_rst_dacdata", 32'(dacdata), 32'd0);
        dacrst  = 1'b0;
        drv_lat = 1;
        step();
        if (RepeatEn) exp_q.push_back(12'h000);
        enable = 1'b1;
        step();
        enable = 1'b0;
        @(negedge dacclk);
        check("t5_underrun_set", 32'(underrun), 32'd1);
        check("t5_dacdav_repeat", 32'(dacdav), 32'(RepeatEn));
        wait_idle(20, "t5_idle");
        pulse_clr();
        @(negedge dacclk);
        check("t5_clr_underrun", 32'(underrun), 32'd0);

        // T6: push into empty FIFO on the same cycle as a tick
        rises.delete();
        step();
        rate_div = 16'd3;
        enable   = 1'b1;
        t0       = cyc;
        step();
        step();
        step();
        if (RepeatEn) exp_q.push_back(12'h000);
        push(12'hFFF, 1'b1);
        @(negedge dacclk);
        check("t6_level1", 32'(level), 32'd1);
        check("t6_underrun", 32'(underrun), 32'd1);
        check("t6_no_pop_dacdav", 32'(dacdav), 32'(RepeatEn));
        wait_rises(RepeatEn ? 2 : 1, 40, "t6_send");
        enable = 1'b0;
        check("t6_send_time", 32'(rise_at(RepeatEn ? 1 : 0) - t0), RepeatEn ? 32'd12 : 32'd8);
        wait_idle(40, "t6_idle");
        check("t6_empty", 32'(empty), 32'd1);

        repeat (5) step();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
